// File: rtl/spi_slave_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave_core
// Purpose  : Single-lane SPI target running entirely in the clk_i domain.
//            SCK, NSS and MOSI are oversampled through synchronizers and
//            edge-detected. Local logic sees a byte-wide receive pulse
//            interface and a one-entry transmit holding register.
// Ports    : clk_i          system clock (f_sck <= f_clk/8)
//            rst_n_i        asynchronous active-low reset
//            spi_sck_i      SPI clock from the master
//            spi_nss_i      chip select, active low
//            spi_mosi_i     master-out data
//            spi_miso_o     slave-out data
//            spi_miso_en_o  MISO pad output enable (1 = drive)
//            tx_valid_i     TX byte offered
//            tx_data_i      TX byte
//            tx_ready_o     TX holding register empty
//            tx_underrun_o  one-cycle pulse: DUMMY_BYTE was loaded
//            rx_valid_o     one-cycle pulse: rx_data_o holds a new byte
//            rx_data_o      last received byte
//            busy_o         frame in progress (synchronized NSS low)
//            frame_done_o   one-cycle pulse at end of frame
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_core #(
    parameter bit         CPOL        = 1'b0,
    parameter bit         CPHA        = 1'b0,
    parameter bit         LSB_FIRST   = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spi_sck_i,
    input  logic       spi_nss_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_en_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    // A single flop is not a synchronizer; clamp the depth to at least two.
    localparam int c_SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------------
    logic [c_SYNC_DEPTH-1:0] r_sck_sync;
    logic [c_SYNC_DEPTH-1:0] r_nss_sync;
    logic [c_SYNC_DEPTH-1:0] r_mosi_sync;
    logic                    r_sck_d;

    logic w_sck_s;
    logic w_nss_s;
    logic w_mosi_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sck_sync  <= {c_SYNC_DEPTH{CPOL}};
            r_nss_sync  <= {c_SYNC_DEPTH{1'b1}};
            r_mosi_sync <= '0;
            r_sck_d     <= CPOL;
        end else begin
            r_sck_sync  <= {r_sck_sync[c_SYNC_DEPTH-2:0], spi_sck_i};
            r_nss_sync  <= {r_nss_sync[c_SYNC_DEPTH-2:0], spi_nss_i};
            r_mosi_sync <= {r_mosi_sync[c_SYNC_DEPTH-2:0], spi_mosi_i};
            r_sck_d     <= w_sck_s;
        end
    end

    assign w_sck_s  = r_sck_sync[c_SYNC_DEPTH-1];
    assign w_nss_s  = r_nss_sync[c_SYNC_DEPTH-1];
    assign w_mosi_s = r_mosi_sync[c_SYNC_DEPTH-1];

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_frame_start;
    logic   w_frame_end;
    logic   r_frame_done;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_nss_s) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_nss_s) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // SCK edge classification. Leading = away from the idle level.
    // Edges only count inside a frame with NSS still asserted.
    // ------------------------------------------------------------------------
    logic w_sck_lead;
    logic w_sck_trail;
    logic w_edge_en;
    logic w_sample_edge;
    logic w_shift_edge;

    assign w_sck_lead    = (r_sck_d == CPOL) && (w_sck_s != CPOL);
    assign w_sck_trail   = (r_sck_d != CPOL) && (w_sck_s == CPOL);
    assign w_edge_en     = (r_state == ST_ACTIVE) && !w_nss_s;
    assign w_sample_edge = w_edge_en && (CPHA ? w_sck_trail : w_sck_lead);
    assign w_shift_edge  = w_edge_en && (CPHA ? w_sck_lead  : w_sck_trail);

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------
    logic [7:0] r_rx_shift;
    logic [2:0] r_rx_cnt;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [7:0] w_rx_shift_nxt;

    assign w_rx_shift_nxt = LSB_FIRST ? {w_mosi_s, r_rx_shift[7:1]}
                                      : {r_rx_shift[6:0], w_mosi_s};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_shift <= 8'h00;
            r_rx_cnt   <= 3'd0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_frame_start || w_frame_end) begin
                // A partial byte at frame end is simply dropped.
                r_rx_shift <= 8'h00;
                r_rx_cnt   <= 3'd0;
            end else if (w_sample_edge) begin
                r_rx_shift <= w_rx_shift_nxt;
                r_rx_cnt   <= r_rx_cnt + 3'd1;
                if (r_rx_cnt == 3'd7) begin
                    r_rx_data  <= w_rx_shift_nxt;
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit path
    // CPHA=0: the first bit must be on MISO before the first sample edge, so
    //         the byte is loaded at frame start and after every 8th shift.
    // CPHA=1: the first shift edge of a byte both loads and presents bit 0;
    //         r_tx_loaded tells the very first edge of a frame apart.
    // ------------------------------------------------------------------------
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [7:0] r_tx_byte;
    logic [2:0] r_tx_bit;
    logic       r_tx_loaded;
    logic       r_tx_underrun;
    logic       w_load;
    logic       w_accept;
    logic [2:0] w_tx_idx;

    assign w_load = CPHA ? (w_shift_edge && (!r_tx_loaded || (r_tx_bit == 3'd7)))
                         : (w_frame_start || (w_shift_edge && (r_tx_bit == 3'd7)));

    assign w_accept = tx_valid_i && !r_hold_full;
    assign w_tx_idx = LSB_FIRST ? r_tx_bit : (3'd7 - r_tx_bit);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_byte     <= 8'h00;
            r_tx_bit      <= 3'd0;
            r_tx_loaded   <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_frame_start || w_frame_end) begin
                r_tx_bit    <= 3'd0;
                r_tx_loaded <= 1'b0;
            end
            if (w_load) begin
                if (r_hold_full) begin
                    r_tx_byte <= r_hold;
                end else begin
                    r_tx_byte     <= DUMMY_BYTE;
                    r_tx_underrun <= 1'b1;
                end
                r_tx_bit    <= 3'd0;
                r_tx_loaded <= 1'b1;
            end else if (w_shift_edge) begin
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end
    end

    // Holding register. An accept can only happen while empty, so a load in
    // the same cycle always takes the dummy and the new byte waits here.
    // Frame boundaries leave the holding register untouched.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= tx_data_i;
                r_hold_full <= 1'b1;
            end else if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign spi_miso_o    = (r_state == ST_ACTIVE) && r_tx_byte[w_tx_idx];
    assign spi_miso_en_o = (r_state == ST_ACTIVE);
    assign busy_o        = (r_state == ST_ACTIVE);
    assign frame_done_o  = r_frame_done;
    assign tx_ready_o    = !r_hold_full;
    assign tx_underrun_o = r_tx_underrun;
    assign rx_valid_o    = r_rx_valid;
    assign rx_data_o     = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_core
// Purpose  : Directed self-checking bench. Three targets share one clock:
//            index 0 = mode 0 MSB-first, 1 = mode 3 MSB-first,
//            2 = mode 1 LSB-first. A behavioural master drives each at
//            f_sck = f_clk/8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_core;

    localparam int       HALF   = 40;       // half SCK period, 4 clk cycles
    localparam bit [2:0] CPOL_V = 3'b010;
    localparam bit [2:0] CPHA_V = 3'b110;
    localparam bit [2:0] LSB_V  = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sck;
    logic [2:0] nss;
    logic [2:0] mosi;
    logic [2:0] tx_valid;
    logic [7:0] tx_data [3];

    wire  [2:0] miso;
    wire  [2:0] miso_en;
    wire  [2:0] tx_ready;
    wire  [2:0] underrun;
    wire  [2:0] rx_valid;
    wire  [2:0] busy;
    wire  [2:0] frame_done;
    wire  [7:0] rx_data [3];

    int         n_pass  = 0;
    int         n_fail  = 0;
    int         n_total = 0;
    int         rx_n [3] = '{0, 0, 0};
    int         fd_n [3] = '{0, 0, 0};
    int         ur_n [3] = '{0, 0, 0};
    logic [7:0] rx_log [3][8];

    always #5 clk = ~clk;

    spi_slave_core #(.CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u_m0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .spi_sck_i(sck[0]), .spi_nss_i(nss[0]), .spi_mosi_i(mosi[0]),
        .spi_miso_o(miso[0]), .spi_miso_en_o(miso_en[0]),
        .tx_valid_i(tx_valid[0]), .tx_data_i(tx_data[0]),
        .tx_ready_o(tx_ready[0]), .tx_underrun_o(underrun[0]),
        .rx_valid_o(rx_valid[0]), .rx_data_o(rx_data[0]),
        .busy_o(busy[0]), .frame_done_o(frame_done[0])
    );

    spi_slave_core #(.CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u_m3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .spi_sck_i(sck[1]), .spi_nss_i(nss[1]), .spi_mosi_i(mosi[1]),
        .spi_miso_o(miso[1]), .spi_miso_en_o(miso_en[1]),
        .tx_valid_i(tx_valid[1]), .tx_data_i(tx_data[1]),
        .tx_ready_o(tx_ready[1]), .tx_underrun_o(underrun[1]),
        .rx_valid_o(rx_valid[1]), .rx_data_o(rx_data[1]),
        .busy_o(busy[1]), .frame_done_o(frame_done[1])
    );

    spi_slave_core #(.CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_m1l (
        .clk_i(clk), .rst_n_i(rst_n),
        .spi_sck_i(sck[2]), .spi_nss_i(nss[2]), .spi_mosi_i(mosi[2]),
        .spi_miso_o(miso[2]), .spi_miso_en_o(miso_en[2]),
        .tx_valid_i(tx_valid[2]), .tx_data_i(tx_data[2]),
        .tx_ready_o(tx_ready[2]), .tx_underrun_o(underrun[2]),
        .rx_valid_o(rx_valid[2]), .rx_data_o(rx_data[2]),
        .busy_o(busy[2]), .frame_done_o(frame_done[2])
    );

    // Pulse counters and receive log
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rx_valid[d] === 1'b1) begin
                if (rx_n[d] < 8) rx_log[d][rx_n[d]] <= rx_data[d];
                rx_n[d] <= rx_n[d] + 1;
            end
            if (frame_done[d] === 1'b1) fd_n[d] <= fd_n[d] + 1;
            if (underrun[d] === 1'b1)   ur_n[d] <= ur_n[d] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wait(input int d, input logic [7:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", tx_ready[d], 1'b1);
        tx_valid[d] = 1'b1;
        tx_data[d]  = v;
        @(negedge clk);
        tx_valid[d] = 1'b0;
    endtask

    task automatic frame_begin(input int d, output logic rdy_before, output logic rdy_at);
        int n;
        n          = 0;
        rdy_before = tx_ready[d];
        nss[d]     = 1'b0;
        @(negedge clk);
        while (busy[d] !== 1'b1 && n < 50) begin
            rdy_before = tx_ready[d];
            @(negedge clk);
            n++;
        end
        rdy_at = tx_ready[d];
        check("busy_rise", busy[d], 1'b1);
        check("miso_en_rise", miso_en[d], 1'b1);
        #HALF;
    endtask

    task automatic frame_end(input int d);
        #HALF;
        nss[d] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_byte(input int d, input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi);
        int b;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            b = LSB_V[d] ? i : 7 - i;
            if (!CPHA_V[d]) begin
                mosi[d] = mo[b];
                #HALF;
                mi[b]   = miso[d];
                sck[d]  = ~CPOL_V[d];
                #HALF;
                sck[d]  = CPOL_V[d];
            end else begin
                sck[d]  = ~CPOL_V[d];
                mosi[d] = mo[b];
                #HALF;
                mi[b]   = miso[d];
                sck[d]  = CPOL_V[d];
                #HALF;
            end
        end
    endtask

    initial begin : main
        logic [7:0] m0, m1, m2;
        logic       rb, ra;
        int         base_rx, base_fd, base_ur;

        rst_n    = 1'b0;
        sck      = CPOL_V;
        nss      = 3'b111;
        mosi     = 3'b000;
        tx_valid = 3'b000;
        for (int d = 0; d < 3; d++) tx_data[d] = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_miso",     miso[0],       1'b0);
        check("rst_miso_en",  miso_en[0],    1'b0);
        check("rst_tx_ready", tx_ready[0],   1'b1);
        check("rst_underrun", underrun[0],   1'b0);
        check("rst_rx_valid", rx_valid[0],   1'b0);
        check("rst_rx_data",  rx_data[0],    8'h00);
        check("rst_busy",     busy[0],       1'b0);
        check("rst_fdone",    frame_done[0], 1'b0);
        check("rst_ready_m3", tx_ready[1],   1'b1);

        // Mode 0: preload A5, master sends 3C
        push_wait(0, 8'hA5);
        check("m0_ready_full", tx_ready[0], 1'b0);
        frame_begin(0, rb, ra);
        check("m0_ready_before_load", rb, 1'b0);
        check("m0_ready_after_load",  ra, 1'b1);
        spi_byte(0, 8'h3C, 8, m0);
        frame_end(0);
        check("m0_master_rx", m0,          8'hA5);
        check("m0_rx_data",   rx_data[0],  8'h3C);
        check("m0_rx_pulses", rx_n[0],     1);
        check("m0_fdone",     fd_n[0],     1);
        check("m0_underrun",  ur_n[0],     1);
        check("m0_busy_end",  busy[0],     1'b0);
        check("m0_en_end",    miso_en[0],  1'b0);
        check("m0_miso_idle", miso[0],     1'b0);

        // Mode 3: 3-byte frame, second byte pushed during byte 0
        push_wait(1, 8'h81);
        frame_begin(1, rb, ra);
        fork
            begin
                spi_byte(1, 8'h11, 8, m0);
                spi_byte(1, 8'h22, 8, m1);
                spi_byte(1, 8'h33, 8, m2);
            end
            begin
                #(3*HALF);
                push_wait(1, 8'h7E);
            end
        join
        frame_end(1);
        check("m3_master_b0", m0,           8'h81);
        check("m3_master_b1", m1,           8'h7E);
        check("m3_master_b2", m2,           8'hFF);
        check("m3_underrun",  ur_n[1],      1);
        check("m3_rx_pulses", rx_n[1],      3);
        check("m3_rx0",       rx_log[1][0], 8'h11);
        check("m3_rx1",       rx_log[1][1], 8'h22);
        check("m3_rx2",       rx_log[1][2], 8'h33);
        check("m3_fdone",     fd_n[1],      1);

        // Mode 1, LSB first
        push_wait(2, 8'h80);
        frame_begin(2, rb, ra);
        spi_byte(2, 8'h01, 8, m0);
        frame_end(2);
        check("lsb_master_rx", m0,         8'h80);
        check("lsb_rx_data",   rx_data[2], 8'h01);
        check("lsb_rx_pulses", rx_n[2],    1);
        check("lsb_underrun",  ur_n[2],    0);

        // NSS rise after 5 bits, then a full byte
        base_rx = rx_n[0];
        base_fd = fd_n[0];
        frame_begin(0, rb, ra);
        spi_byte(0, 8'hF0, 5, m0);
        frame_end(0);
        check("part_no_rx",  rx_n[0], base_rx);
        check("part_fdone",  fd_n[0], base_fd + 1);
        frame_begin(0, rb, ra);
        spi_byte(0, 8'hC3, 8, m0);
        frame_end(0);
        check("part_next_rx",    rx_n[0],    base_rx + 1);
        check("part_next_data",  rx_data[0], 8'hC3);
        check("part_next_dummy", m0,         8'hFF);

        // tx_valid held high while full, byte pushed at load point follows
        push_wait(0, 8'h5A);
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hC7;
        repeat (3) @(negedge clk);
        check("hold_no_accept", tx_ready[0], 1'b0);
        base_ur = ur_n[0];
        frame_begin(0, rb, ra);
        spi_byte(0, 8'h00, 8, m0);
        spi_byte(0, 8'h00, 8, m1);
        frame_end(0);
        tx_valid[0] = 1'b0;
        @(negedge clk);
        check("hold_first",     m0,          8'h5A);
        check("hold_second",    m1,          8'hC7);
        check("hold_no_dummy",  ur_n[0],     base_ur);
        check("hold_kept_full", tx_ready[0], 1'b0);

        // Asynchronous reset mid-byte
        base_fd = fd_n[0];
        frame_begin(0, rb, ra);
        spi_byte(0, 8'hAA, 4, m0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",     busy[0],       1'b0);
        check("arst_miso_en",  miso_en[0],    1'b0);
        check("arst_miso",     miso[0],       1'b0);
        check("arst_tx_ready", tx_ready[0],   1'b1);
        check("arst_rx_data",  rx_data[0],    8'h00);
        check("arst_fdone",    frame_done[0], 1'b0);
        nss = 3'b111;
        sck = CPOL_V;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_rel_ready",  tx_ready[0], 1'b1);
        check("arst_rel_en",     miso_en[0],  1'b0);
        check("arst_rel_nofd",   fd_n[0],     base_fd);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
